// File: rtl/systolic_drain.sv
// Output drain for the systolic array: sweeps matrix_index, requantizes each accumulator lane and
// packs lanes into SRAM write words. Define SYSTOLIC_DRAIN_RELU_EN to fuse a ReLU after saturation.
module systolic_drain #(
  parameter int unsigned ARRAY_SIZE      = 8,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned CUM_BITS_EXT    = 5,
  parameter int unsigned ORI_WIDTH       = DATA_WIDTH * 2 + CUM_BITS_EXT,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned QUEUE_SIZE      = 4,
  parameter int unsigned QUEUE_COUNT     = (ARRAY_SIZE + QUEUE_SIZE - 1) / QUEUE_SIZE,
  parameter int unsigned SRAM_DATA_WIDTH = 32,
  parameter int unsigned MATRIX_BITS     = 6,
  parameter int unsigned SHIFT_BITS      = 5,
  parameter int unsigned ADDR_BITS       = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_BITS-1:0]                   base_addr,
  input  logic [SHIFT_BITS-1:0]                  shift_amt,
  input  logic [ARRAY_SIZE*ORI_WIDTH-1:0]        mul_outcome,
  output logic [MATRIX_BITS-1:0]                 matrix_index,
  output logic                                   sram_wen,
  input  logic                                   sram_wready,
  output logic [ADDR_BITS-1:0]                   sram_waddr,
  output logic [SRAM_DATA_WIDTH*QUEUE_COUNT-1:0] sram_wdata_packed,
  output logic                                   busy,
  output logic                                   done
);

  localparam int unsigned EXT_W     = ORI_WIDTH + 1;
  localparam int unsigned SHIFT_MAX = ORI_WIDTH - 1;
  localparam int unsigned PACK_W    = SRAM_DATA_WIDTH * QUEUE_COUNT;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [MATRIX_BITS-1:0]  LAST_IDX = MATRIX_BITS'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t                          state;
  logic [ADDR_BITS-1:0]            base_lat;
  logic [SHIFT_BITS-1:0]           shift_lat;
  logic                            idx_valid;
  logic                            cap_valid;
  logic [MATRIX_BITS-1:0]          cap_idx;
  logic [ARRAY_SIZE*ORI_WIDTH-1:0] cap_data;
  logic [MATRIX_BITS-1:0]          wr_cnt;
  logic [PACK_W-1:0]               pack_c;
  logic                            advance_c;

  // Round-half-up arithmetic shift in one extra bit, then saturate (and optionally ReLU).
  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ORI_WIDTH-1:0] x,
                                                   input logic [SHIFT_BITS-1:0] s);
    logic signed [EXT_W-1:0] xe;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] t;
    logic [OUT_WIDTH-1:0]    q;
    xe  = {x[ORI_WIDTH-1], x};
    rnd = '0;
    if (s == '0) begin
      t = xe;
    end else begin
      rnd = EXT_W'(1) << (s - SHIFT_BITS'(1));
      t   = (xe + rnd) >>> s;
    end
    if (t > SAT_MAX)      q = SAT_MAX[OUT_WIDTH-1:0];
    else if (t < SAT_MIN) q = SAT_MIN[OUT_WIDTH-1:0];
    else                  q = t[OUT_WIDTH-1:0];
`ifdef SYSTOLIC_DRAIN_RELU_EN
    if (q[OUT_WIDTH-1]) q = '0;
`else
    q = q;
`endif
    return q;
  endfunction

  assign advance_c = !(sram_wen && !sram_wready);

  // Lane L = k*QUEUE_SIZE+i lands in word k, lane 0 of each word in the MSBs.
  for (genvar k = 0; k < QUEUE_COUNT; k++) begin : g_word
    for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_slot
      localparam int unsigned L   = k * QUEUE_SIZE + i;
      localparam int unsigned POS = k * SRAM_DATA_WIDTH + (QUEUE_SIZE - 1 - i) * OUT_WIDTH;
      if (L < ARRAY_SIZE) begin : g_lane
        assign pack_c[POS +: OUT_WIDTH] = requant(cap_data[L*ORI_WIDTH +: ORI_WIDTH], shift_lat);
      end else begin : g_pad
        assign pack_c[POS +: OUT_WIDTH] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      base_lat          <= '0;
      shift_lat         <= '0;
      matrix_index      <= '0;
      idx_valid         <= 1'b0;
      cap_valid         <= 1'b0;
      cap_idx           <= '0;
      cap_data          <= '0;
      wr_cnt            <= '0;
      sram_wen          <= 1'b0;
      sram_waddr        <= '0;
      sram_wdata_packed <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_SWEEP;
            busy         <= 1'b1;
            base_lat     <= base_addr;
            shift_lat    <= (shift_amt > SHIFT_BITS'(SHIFT_MAX)) ? SHIFT_BITS'(SHIFT_MAX) : shift_amt;
            matrix_index <= '0;
            idx_valid    <= 1'b1;
            wr_cnt       <= '0;
          end
        end
        S_SWEEP: begin
          // Index counter -> capture -> output; the whole pipe freezes while a write is refused.
          if (advance_c) begin
            if (idx_valid) begin
              cap_data <= mul_outcome;
              cap_idx  <= matrix_index;
              if (matrix_index == LAST_IDX) idx_valid    <= 1'b0;
              else                          matrix_index <= matrix_index + MATRIX_BITS'(1);
            end
            cap_valid <= idx_valid;
            sram_wen  <= cap_valid;
            if (cap_valid) begin
              sram_waddr        <= base_lat + ADDR_BITS'(cap_idx);
              sram_wdata_packed <= pack_c;
            end
          end
          if (sram_wen && sram_wready) begin
            wr_cnt <= wr_cnt + MATRIX_BITS'(1);
            if (wr_cnt == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: table-driven requant sweeps plus stall, reset and start-while-busy
// sequences, all writes checked against a queue of expected {addr, data}.
module tb_systolic_drain;
  localparam int N   = 8;
  localparam int ORI = 21;
`ifdef SYSTOLIC_DRAIN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [9:0]     base_addr;
  logic [4:0]     shift_amt;
  logic [N*ORI-1:0] mul_outcome;
  logic [5:0]     matrix_index;
  logic           sram_wen;
  logic           sram_wready;
  logic [9:0]     sram_waddr;
  logic [63:0]    sram_wdata_packed;
  logic           busy;
  logic           done;

  systolic_drain dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .shift_amt(shift_amt),
    .mul_outcome(mul_outcome), .matrix_index(matrix_index), .sram_wen(sram_wen),
    .sram_wready(sram_wready), .sram_waddr(sram_waddr), .sram_wdata_packed(sram_wdata_packed),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int acc_v [N][N];

  // Array model: lane l of the selected slice at [l*ORI +: ORI].
  always_comb begin
    mul_outcome = '0;
    for (int l = 0; l < N; l++)
      if (matrix_index < 6'(N)) mul_outcome[l*ORI +: ORI] = ORI'(acc_v[matrix_index[2:0]][l]);
  end

  typedef struct { logic [9:0] addr; logic [63:0] data; } wr_t;
  typedef struct { int acc; int sh; logic [7:0] exp; } vec_t;

  wr_t sb[$];
  int  total = 0, bad = 0, cyc = 0, writes = 0, first_cyc = 0, last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] quant(input int x, input int s_in);
    int s, n, d, q, t;
    s = (s_in > 20) ? 20 : s_in;
    if (s == 0) t = x;
    else begin
      n = x + (1 << (s - 1));
      d = 1 << s;
      q = n / d;
      if (n < 0 && q * d != n) q = q - 1;
      t = q;
    end
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    if (RELU && t < 0) t = 0;
    return 8'(t);
  endfunction

  function automatic logic [63:0] model_word(input int m, input int s);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        w[k*32 + (3-i)*8 +: 8] = quant(acc_v[m][k*4+i], s);
    return w;
  endfunction

  // Scoreboard side: every accepted write is popped and compared.
  always @(negedge clk) begin
    if (sram_wen && sram_wready) begin
      wr_t w;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        w = sb.pop_front();
        chk("waddr", 64'(sram_waddr), 64'(w.addr));
        chk("wdata", sram_wdata_packed, w.data);
      end
      if (writes == 0) first_cyc = cyc;
      last_cyc = cyc;
      writes++;
    end
  end

  task automatic push_sweep(input logic [9:0] b, input int s, input bit use_const, input logic [7:0] cb);
    wr_t w;
    for (int m = 0; m < N; m++) begin
      w.addr = b + 10'(m);
      w.data = use_const ? {8{cb}} : model_word(m, s);
      sb.push_back(w);
    end
  endtask

  task automatic do_start(input logic [9:0] b, input logic [4:0] s);
    writes = 0;
    @(posedge clk); #1;
    base_addr = b; shift_amt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit b2b);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    if (!found) chk("done_seen", 64'(done), 64'(1));
    else begin
      chk("done_latency", 64'(cyc), 64'(last_cyc + 1));
      chk("busy_in_done", 64'(busy), 64'(1));
      chk("write_count", 64'(writes), 64'(N));
      chk("sb_empty", 64'(sb.size()), 64'(0));
      if (b2b) chk("back_to_back", 64'(last_cyc - first_cyc), 64'(N - 1));
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'(0));
      chk("busy_idle", 64'(busy), 64'(0));
    end
  endtask

  task automatic fill_const(input int v);
    for (int m = 0; m < N; m++) for (int l = 0; l < N; l++) acc_v[m][l] = v;
  endtask

  task automatic fill_rand();
    for (int m = 0; m < N; m++)
      for (int l = 0; l < N; l++) acc_v[m][l] = int'($urandom_range(6000, 0)) - 3000;
  endtask

  task automatic wait_addr(input logic [9:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (sram_wen && sram_waddr == a) found = 1'b1;
    end
    if (!found) chk("addr_seen", 64'(sram_waddr), 64'(a));
  endtask

  vec_t vt [10];

  initial begin
    logic [7:0] e;
    logic [9:0] b;
    logic [63:0] w2;
    vt[0] = '{100, 2, 8'h19};
    vt[1] = '{6, 2, 8'h02};
    vt[2] = '{-6, 2, 8'hFF};
    vt[3] = '{5, 2, 8'h01};
    vt[4] = '{7, 0, 8'h07};
    vt[5] = '{1000, 0, 8'h7F};
    vt[6] = '{-1000, 0, 8'h80};
    vt[7] = '{1048575, 20, 8'h01};
    vt[8] = '{1048575, 31, 8'h01};
    vt[9] = '{-50, 0, 8'hCE};

    rst = 1'b1; start = 1'b0; base_addr = '0; shift_amt = '0; sram_wready = 1'b1;
    fill_const(0);
    #12;
    chk("rst_matrix_index", 64'(matrix_index), 64'(0));
    chk("rst_wen", 64'(sram_wen), 64'(0));
    chk("rst_waddr", 64'(sram_waddr), 64'(0));
    chk("rst_wdata", sram_wdata_packed, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of uniform-lane sweeps: rounding, saturation, clamp, sign.
    for (int i = 0; i < 10; i++) begin
      e = (RELU && vt[i].exp[7]) ? 8'h00 : vt[i].exp;
      b = (i == 0) ? 10'h010 : 10'(i * 37);
      fill_const(vt[i].acc);
      push_sweep(b, vt[i].sh, 1'b1, e);
      do_start(b, 5'(vt[i].sh));
      wait_done(1'b1);
    end

    // Mixed lanes, address wrap, and a start pulse while busy that must be ignored.
    fill_rand();
    push_sweep(10'h3FC, 3, 1'b0, 8'h00);
    do_start(10'h3FC, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    base_addr = 10'h155; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_mid_sweep", 64'(busy), 64'(1));
    wait_done(1'b1);

    // Stall on the third write for three cycles.
    fill_rand();
    push_sweep(10'h040, 1, 1'b0, 8'h00);
    w2 = model_word(2, 1);
    do_start(10'h040, 5'd1);
    wait_addr(10'h041);
    @(posedge clk); #1;
    sram_wready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_wen", 64'(sram_wen), 64'(1));
      chk("stall_addr", 64'(sram_waddr), 64'(10'h042));
      chk("stall_data", sram_wdata_packed, w2);
      chk("stall_index", 64'(matrix_index), 64'(4));
    end
    @(posedge clk); #1;
    sram_wready = 1'b1;
    wait_done(1'b0);

    // Asynchronous reset after four writes, then a clean full sweep.
    fill_const(-3);
    push_sweep(10'h080, 0, 1'b1, RELU ? 8'h00 : 8'hFD);
    do_start(10'h080, 5'd0);
    wait_addr(10'h083);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_wen", 64'(sram_wen), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_index", 64'(matrix_index), 64'(0));
    chk("midrst_writes", 64'(writes), 64'(4));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_sweep(10'h0A0, 0, 1'b1, RELU ? 8'h00 : 8'hFD);
    do_start(10'h0A0, 5'd0);
    wait_done(1'b1);

    repeat (3) @(negedge clk);
    chk("idle_wen", 64'(sram_wen), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
